player_bullet: RTL and testbench
================================

// Module: player_bullet
// PURPOSE
//  Player missile controller; sits directly upstream of the invader formation block.
//  - Launches one bullet from the player column on a fire press and steps it up one line per step tick.
//  - Drives the bullet coordinates the formation block compares against; consumes its hit flag.
//  - Retires the bullet on hit or on leaving the top of the field; one bullet in flight at a time.
// PARAMETERS
//  STEP_CYCLES     360000  clock cycles per bullet step (10 ms at 36 MHz)
//  START_Y         14      line the bullet occupies on launch (player line is 15)
//  MAX_X           19      highest valid column (formation is 20 columns wide)
//  COOLDOWN_STEPS  2       step ticks spent in COOLDOWN before re-arming
// PORTS
//  i_clk_36MHz     in   1  system clock, 36 MHz
//  i_reset         in   1  asynchronous reset, active-low
//  i_fire          in   1  fire button, asynchronous to clock, active-high
//  i_player_x      in   5  player column
//  i_hit           in   1  hit flag from formation block, synchronous to clock
//  o_bullet_x      out  5  bullet column
//  o_bullet_y      out  4  bullet line; 0 = no bullet
//  o_active        out  1  bullet in flight
//  o_hit_count     out  8  bullets retired by hit, saturating
// BEHAVIOUR
//  Reset (i_reset==0, async)
//   - State IDLE; all outputs 0; prescaler, cooldown counter and synchroniser flops cleared.
//   - Reset mid-flight kills the bullet immediately.
//  Fire input
//   - i_fire passes through a 2-flop synchroniser (f1, f2) plus a registered copy f3.
//   - Press event = f2 & ~f3.
//  Prescaler
//   - Counts 0..STEP_CYCLES-1 and wraps; step = (count==STEP_CYCLES-1).
//   - Forced to 0 on launch, so the first step comes exactly STEP_CYCLES cycles after launch.
//  IDLE
//   - o_bullet_y=0, o_bullet_x=0, o_active=0.
//   - Press event -> FLY. On that clock edge: latch x = min(i_player_x, MAX_X), y=START_Y, o_active=1.
//   - Latency: o_active rises on the 3rd rising edge after i_fire rises, given setup is met.
//  FLY
//   - x is held constant for the whole flight; later i_player_x changes are ignored.
//   - i_hit==1 -> next edge: y=0, x=0, o_active=0, o_hit_count+1 (holds at 255), go to COOLDOWN.
//   - Else on a step with y==1 -> miss; same retire actions except o_hit_count, go to COOLDOWN.
//   - Else on a step -> y=y-1.
//   - i_hit and step in the same cycle: the hit wins and is counted; no decrement.
//   - Press events during FLY are ignored.
//  COOLDOWN
//   - Outputs as in IDLE.
//   - Counts COOLDOWN_STEPS step ticks, then goes to IDLE only when f2==0 (fire released).
//  i_hit outside FLY is ignored.
//  o_bullet_y==0 whenever no bullet is in flight. The formation block compares against line+1 >= 2,
//   so no false hit is possible.
//  State encoding: 2 bits, IDLE=0, FLY=1, COOLDOWN=2. Illegal code 3 -> IDLE on the next edge.
// CONFIGURATION
//  PLAYER_BULLET_AUTOFIRE_EN
//   - Defined: COOLDOWN exits to IDLE after COOLDOWN_STEPS regardless of fire.
//     In IDLE, f2==1 (level) launches, so holding fire auto-repeats.
//   - Undefined: release is required, as in BEHAVIOUR; only press events launch.
// TESTING
//  1. Reset, i_player_x=7, pulse i_fire
//     -> o_active=1, x=7, y=14 on edge 3; y=13 after STEP_CYCLES further cycles.
//  2. Fly without hit
//     -> y steps 14..1; at the next step y=0 and o_active=0. Hold fire: no relaunch.
//        Release: IDLE after 2 steps.
//  3. i_hit pulse while y=9 -> next edge y=0, o_hit_count=1, COOLDOWN. Same with i_hit on a step cycle
//     -> counted, no decrement.
//  4. i_player_x=25 at launch -> o_bullet_x=19. Change i_player_x in flight -> x stays 19.
//  5. Assert i_reset low asynchronously mid-flight (y=6) -> all outputs 0 before the next clock edge.
//     Hold o_hit_count at 255 and hit again -> stays 255.
//  6. With PLAYER_BULLET_AUTOFIRE_EN, hold i_fire high
//     -> relaunch at y=14 one cycle after COOLDOWN ends, with no release needed.

Source files
------------

// File: rtl/player_bullet.sv
// Player missile controller: one bullet in flight, launched from the player column and stepped
// upward by a prescaled tick. Define PLAYER_BULLET_AUTOFIRE_EN to relaunch while fire is held.
module player_bullet #(
  parameter int unsigned STEP_CYCLES    = 360000,
  parameter int unsigned START_Y        = 14,
  parameter int unsigned MAX_X          = 19,
  parameter int unsigned COOLDOWN_STEPS = 2
) (
  input  logic       i_clk_36MHz,
  input  logic       i_reset,
  input  logic       i_fire,
  input  logic [4:0] i_player_x,
  input  logic       i_hit,
  output logic [4:0] o_bullet_x,
  output logic [3:0] o_bullet_y,
  output logic       o_active,
  output logic [7:0] o_hit_count
);

  localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned CW = (COOLDOWN_STEPS > 0) ? $clog2(COOLDOWN_STEPS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_STEPS);
  localparam logic [CW-1:0] CD_ONE   = CW'(1);
  localparam logic [4:0]    X_MAX    = 5'(MAX_X);
  localparam logic [3:0]    Y_START  = 4'(START_Y);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFly      = 2'd1,
    StCooldown = 2'd2
  } state_e;

  state_e        r_state, w_state_d;
  logic          r_f1, r_f2, r_f3;
  logic [PW-1:0] r_pre, w_pre_d;
  logic [CW-1:0] r_cd, w_cd_d;
  logic [4:0]    r_x, w_x_d;
  logic [3:0]    r_y, w_y_d;
  logic          r_active, w_active_d;
  logic [7:0]    r_hits, w_hits_d;
  logic          w_step, w_launch, w_cd_exit_ok;

  assign w_step = (r_pre == PRE_LAST);

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign w_launch     = r_f2;
  assign w_cd_exit_ok = 1'b1;
`else
  assign w_launch     = r_f2 & ~r_f3;
  assign w_cd_exit_ok = ~r_f2;
`endif

  always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
    if (!i_reset) begin
      r_f1     <= 1'b0;
      r_f2     <= 1'b0;
      r_f3     <= 1'b0;
      r_state  <= StIdle;
      r_pre    <= '0;
      r_cd     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_active <= 1'b0;
      r_hits   <= '0;
    end else begin
      r_f1     <= i_fire;
      r_f2     <= r_f1;
      r_f3     <= r_f2;
      r_state  <= w_state_d;
      r_pre    <= w_pre_d;
      r_cd     <= w_cd_d;
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_active <= w_active_d;
      r_hits   <= w_hits_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_pre_d    = w_step ? '0 : r_pre + PRE_ONE;
    w_cd_d     = r_cd;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_active_d = r_active;
    w_hits_d   = r_hits;
    unique case (r_state)
      StIdle: begin
        if (w_launch) begin
          w_state_d  = StFly;
          w_x_d      = (i_player_x > X_MAX) ? X_MAX : i_player_x;
          w_y_d      = Y_START;
          w_active_d = 1'b1;
          w_pre_d    = '0;
        end
      end
      StFly: begin
        // A hit on a step cycle wins over the decrement.
        if (i_hit || (w_step && r_y == 4'd1)) begin
          w_state_d  = StCooldown;
          w_x_d      = '0;
          w_y_d      = '0;
          w_active_d = 1'b0;
          w_cd_d     = '0;
          if (i_hit && r_hits != 8'hFF) w_hits_d = r_hits + 8'd1;
        end else if (w_step) begin
          w_y_d = r_y - 4'd1;
        end
      end
      StCooldown: begin
        if (r_cd == CD_LAST) begin
          if (w_cd_exit_ok) w_state_d = StIdle;
        end else if (w_step) begin
          w_cd_d = r_cd + CD_ONE;
        end
      end
      default: begin
        w_state_d  = StIdle;
        w_x_d      = '0;
        w_y_d      = '0;
        w_active_d = 1'b0;
      end
    endcase
  end

  assign o_bullet_x  = r_x;
  assign o_bullet_y  = r_y;
  assign o_active    = r_active;
  assign o_hit_count = r_hits;

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: every change of the output tuple is checked in order
// against an expected stream, plus direct checks of launch/step timing and async reset.
module tb_player_bullet;

  localparam int unsigned STEP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire;
  logic [4:0] px;
  logic       hit;
  logic [4:0] bx;
  logic [3:0] by;
  logic       act;
  logic [7:0] hits;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] prev = '0;

  player_bullet #(
    .STEP_CYCLES   (STEP),
    .START_Y       (14),
    .MAX_X         (19),
    .COOLDOWN_STEPS(2)
  ) dut (
    .i_clk_36MHz(clk),
    .i_reset    (rst_n),
    .i_fire     (fire),
    .i_player_x (px),
    .i_hit      (hit),
    .o_bullet_x (bx),
    .o_bullet_y (by),
    .o_active   (act),
    .o_hit_count(hits)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(logic a, logic [4:0] x, logic [3:0] y, logic [7:0] c);
    return {a, x, y, c};
  endfunction

  // Monitor: each observed change of {active, x, y, count} consumes one expected tuple.
  initial begin
    forever begin
      @(negedge clk);
      if ({act, bx, by, hits} !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %h expected none", {act, bx, by, hits});
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({act, bx, by, hits} !== e) begin
            errors++;
            $display("FAIL tuple got %h expected %h", {act, bx, by, hits}, e);
          end
        end
        prev = {act, bx, by, hits};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press fire for 3 cycles; returns 1ns after the launch edge.
  task automatic press(input logic [4:0] x, input logic [4:0] exp_x, input logic [7:0] c);
    px = x;
    exp_q.push_back(pk(1'b1, exp_x, 4'd14, c));
    fire = 1'b1;
    tick(2);
    chk("active_before_edge3", {31'd0, act}, 32'd0);
    tick(1);
    chk("active_edge3", {31'd0, act}, 32'd1);
    chk("x_launch", {27'd0, bx}, {27'd0, exp_x});
    fire = 1'b0;
  endtask

  task automatic pulse_hit;
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask

  logic [7:0] cnt;

  initial begin
    rst_n = 1'b0;
    fire  = 1'b0;
    px    = 5'd0;
    hit   = 1'b0;
    cnt   = 8'd0;
    tick(3);
    chk("reset_active", {31'd0, act}, 32'd0);
    chk("reset_y", {28'd0, by}, 32'd0);
    chk("reset_hits", {24'd0, hits}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Launch at x=7, first step exactly STEP cycles later, then fly to a miss.
    press(5'd7, 5'd7, cnt);
    for (int y = 13; y >= 1; y--) exp_q.push_back(pk(1'b1, 5'd7, 4'(y), cnt));
    exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt));
    tick(STEP - 1);
    chk("y_before_step", {28'd0, by}, 32'd14);
    tick(1);
    chk("y_first_step", {28'd0, by}, 32'd13);
    fire = 1'b1;                       // held through flight and cooldown: no relaunch
`ifndef PLAYER_BULLET_AUTOFIRE_EN
    tick(13 * STEP);
    chk("miss_retired", {31'd0, act}, 32'd0);
    tick(6 * STEP);
    chk("held_no_relaunch", {31'd0, act}, 32'd0);
    fire = 1'b0;
    tick(4);
`else
    tick(13 * STEP);
    fire = 1'b0;
    tick(3 * STEP);
`endif

    // Clamp column, ignore later player moves, then hit.
    press(5'd25, 5'd19, cnt);
    exp_q.push_back(pk(1'b1, 5'd19, 4'd13, cnt));
    exp_q.push_back(pk(1'b1, 5'd19, 4'd12, cnt));
    tick(STEP);
    px = 5'd2;
    tick(STEP);
    chk("x_held", {27'd0, bx}, 32'd19);
    exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt + 8'd1));
    pulse_hit();
    cnt = cnt + 8'd1;
    tick(20);

    // Hit at y=9.
    press(5'd3, 5'd3, cnt);
    for (int y = 13; y >= 9; y--) exp_q.push_back(pk(1'b1, 5'd3, 4'(y), cnt));
    exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt + 8'd1));
    tick(5 * STEP);
    chk("y_is_9", {28'd0, by}, 32'd9);
    pulse_hit();
    cnt = cnt + 8'd1;
    chk("hit_y9_count", {24'd0, hits}, 32'd2);
    chk("hit_y9_y", {28'd0, by}, 32'd0);
    tick(20);

    // Hit coincident with a step: counted, no decrement.
    press(5'd10, 5'd10, cnt);
    exp_q.push_back(pk(1'b1, 5'd10, 4'd13, cnt));
    exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt + 8'd1));
    tick(2 * STEP - 1);
    pulse_hit();
    cnt = cnt + 8'd1;
    chk("hit_on_step_count", {24'd0, hits}, 32'd3);
    tick(20);

    // Hit outside flight is ignored (monitor flags any change).
    pulse_hit();
    tick(2);

    // Async reset mid-flight at y=6.
    press(5'd4, 5'd4, cnt);
    for (int y = 13; y >= 6; y--) exp_q.push_back(pk(1'b1, 5'd4, 4'(y), cnt));
    tick(8 * STEP);
    chk("y_is_6", {28'd0, by}, 32'd6);
    exp_q.push_back(pk(1'b0, 5'd0, 4'd0, 8'd0));
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_active", {31'd0, act}, 32'd0);
    chk("async_y", {28'd0, by}, 32'd0);
    chk("async_x", {27'd0, bx}, 32'd0);
    chk("async_hits", {24'd0, hits}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    cnt = 8'd0;
    tick(2);

    // Saturate the hit counter.
    for (int i = 0; i < 256; i++) begin
      press(5'd1, 5'd1, cnt);
      cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt));
      pulse_hit();
      tick(20);
    end
    chk("hits_saturated", {24'd0, hits}, 32'd255);

`ifdef PLAYER_BULLET_AUTOFIRE_EN
    begin
      int k;
      press(5'd5, 5'd5, cnt);
      fire = 1'b1;
      exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt));
      exp_q.push_back(pk(1'b1, 5'd5, 4'd14, cnt));
      pulse_hit();
      k = 0;
      while (!act && k < 40) begin
        tick(1);
        k++;
      end
      chk("autofire_relaunch", {31'd0, act}, 32'd1);
      chk("autofire_y", {28'd0, by}, 32'd14);
      fire = 1'b0;
      exp_q.push_back(pk(1'b0, 5'd0, 4'd0, cnt));
      pulse_hit();
      tick(20);
    end
`endif

    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
        tick(1);
        k++;
      end
      chk("scoreboard_drained", exp_q.size(), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
